row_collector_sipo: RTL

//  Serial-in, parallel-out row assembler for the systolic array output side: the mirror of the

---
 rtl/row_collector_sipo_pkg.sv | 11 +
 rtl/row_collector_sipo_if.sv | 28 ++
 rtl/row_collector_sipo_out_reg.sv | 41 ++++
 rtl/row_collector_sipo.sv | 102 ++++++++++
 4 files changed

// File: rtl/row_collector_sipo_pkg.sv
// Shared systolic-array types and defaults; the input FIFO uses the same row index convention.
package systolic_pkg;

    localparam int unsigned DEF_DIM  = 8;
    localparam int unsigned DEF_BITS = 8;
    localparam int unsigned CNT_W    = $clog2(DEF_DIM + 1);

    typedef logic [DEF_BITS-1:0] elem_t;
    typedef elem_t [DEF_DIM-1:0] row_t;

endpackage

// File: rtl/row_collector_sipo_if.sv
// Element-in / row-out handshake bundle for the row collector.
interface row_collector_sipo_if
    import systolic_pkg::*;
#(
    parameter int unsigned DIM  = DEF_DIM,
    parameter int unsigned BITS = DEF_BITS
);

    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_row [DIM];
    logic            out_partial;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_row, out_partial
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_row, out_partial
    );

endinterface

// File: rtl/row_collector_sipo_out_reg.sv
// Output holding register: loads a full row, presents it on valid/ready, tags padded rows.
module row_out_reg
    import systolic_pkg::*;
#(
    parameter int unsigned W = DEF_DIM * DEF_BITS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_row,
    input  logic         load_partial,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_row,
    output logic         out_partial
);

    logic         valid_q;
    logic [W-1:0] row_q;
    logic         partial_q;

    // The caller only asserts load when the slot is free, so load wins over out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            row_q     <= '0;
            partial_q <= 1'b0;
        end else if (load) begin
            valid_q   <= 1'b1;
            row_q     <= load_row;
            partial_q <= load_partial;
        end else if (out_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign out_valid   = valid_q;
    assign out_row     = row_q;
    assign out_partial = partial_q;

endmodule

// File: rtl/row_collector_sipo.sv
// Serial-in, parallel-out row assembler with one pending row behind the output register.
module row_collector_sipo
    import systolic_pkg::*;
#(
    parameter int unsigned DIM  = DEF_DIM,
    parameter int unsigned BITS = DEF_BITS
) (
    input logic                 clk,
    input logic                 rst_n,
    row_collector_sipo_if.slave bus
);

    localparam int unsigned W  = DIM * BITS;
    localparam int unsigned CW = $clog2(DIM + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIM);

    logic [W-1:0]  asm_q, asm_d, asm_s, asm_p;
    logic [CW-1:0] cnt_q, cnt_d, cnt_s;
    logic          part_q, part_d;
    logic          pending, accept, slot_free, pad, complete;
    logic          load, load_partial;
    logic [W-1:0]  load_row;
    logic          out_valid, out_partial;
    logic [W-1:0]  out_row_flat;

    assign pending      = (cnt_q == CNT_FULL);
    assign bus.in_ready = !pending;
    assign accept       = bus.in_valid && !pending;
    assign slot_free    = !out_valid || bus.out_ready;

    always_comb begin
        asm_s = asm_q;
        cnt_s = cnt_q;
        if (accept) begin
            asm_s = {asm_q[W-BITS-1:0], bus.in_data};
            cnt_s = cnt_q + 1'b1;
        end
        // Padding shifts the partial row up so its first element lands at index DIM-1.
        pad      = bus.flush && (cnt_s != '0) && (cnt_s != CNT_FULL);
        asm_p    = pad ? (asm_s << ((DIM - 32'(cnt_s)) * BITS)) : asm_s;
        complete = !pending && ((cnt_s == CNT_FULL) || pad);

        asm_d        = asm_p;
        cnt_d        = cnt_s;
        part_d       = part_q;
        load         = 1'b0;
        load_row     = asm_p;
        load_partial = pad;

        if (pending) begin
            asm_d = asm_q;
            if (slot_free) begin
                load         = 1'b1;
                load_row     = asm_q;
                load_partial = part_q;
                cnt_d        = '0;
            end
        end else if (complete) begin
            if (slot_free) begin
                load  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d  = CNT_FULL;
                part_d = pad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q  <= '0;
            cnt_q  <= '0;
            part_q <= 1'b0;
        end else begin
            asm_q  <= asm_d;
            cnt_q  <= cnt_d;
            part_q <= part_d;
        end
    end

    row_out_reg #(
        .W (W)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .load_row     (load_row),
        .load_partial (load_partial),
        .out_ready    (bus.out_ready),
        .out_valid    (out_valid),
        .out_row      (out_row_flat),
        .out_partial  (out_partial)
    );

    for (genvar i = 0; i < DIM; i++) begin : g_row
        assign bus.out_row[i] = out_row_flat[i*BITS +: BITS];
    end

    assign bus.out_valid   = out_valid;
    assign bus.out_partial = out_partial;

endmodule
